// File: rtl/stopwatch_lap_timer_if.sv
// Control, count and lap-FIFO signals of the stopwatch/lap timer.
// The master drives the controls and the slave drives the status.
interface stopwatch_lap_timer_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic                  start;
   logic                  stop;
   logic                  clear;
   logic                  dir;
   logic                  lap;
   logic                  lap_pop;
   logic [DATA_WIDTH-1:0] count;
   logic                  running;
   logic                  wrap;
   logic [DATA_WIDTH-1:0] lap_data;
   logic                  lap_valid;
   logic                  lap_full;
   logic                  lap_ovf;

   modport master (
      output start, stop, clear, dir, lap, lap_pop,
      input  count, running, wrap, lap_data, lap_valid, lap_full, lap_ovf
   );

   modport slave (
      input  start, stop, clear, dir, lap, lap_pop,
      output count, running, wrap, lap_data, lap_valid, lap_full, lap_ovf
   );
endinterface

// File: rtl/stopwatch_lap_timer.sv
// Up/down stopwatch with wrap limit, tick prescaler and a show-ahead lap FIFO
// that snapshots the count without stopping the timer.
module stopwatch_lap_timer #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX        = 99,
   parameter int PRESCALE   = 1,
   parameter int LAP_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   stopwatch_lap_timer_if.slave bus
);
   localparam int AW = $clog2(LAP_DEPTH);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [DATA_WIDTH-1:0] MAX_V   = DATA_WIDTH'(MAX);
   localparam logic [PW-1:0]         P_LAST  = PW'(PRESCALE - 1);
   localparam logic [AW:0]           DEPTH_V = (AW+1)'(LAP_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         pcnt_q, pcnt_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic                  wrap_q, wrap_d;
   logic                  run_eff, tick;

   logic [DATA_WIDTH-1:0] mem [LAP_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           fill;
   logic                  lap_ovf_q;
   logic                  push_req, pop_ok, push_ok, full, empty;

   always_comb begin
      state_d = state_q;
      if (bus.stop)
         state_d = IDLE;
      else if (bus.start)
         state_d = RUN;
   end

   // A start pulse already counts in the cycle it is seen; clear suppresses the tick.
   assign run_eff = !bus.stop && (state_q == RUN || bus.start);
   assign tick    = run_eff && !bus.clear && (pcnt_q == P_LAST);

   always_comb begin
      pcnt_d  = pcnt_q;
      count_d = count_q;
      wrap_d  = 1'b0;
      if (bus.clear) begin
         pcnt_d  = '0;
         count_d = '0;
      end else begin
         if (run_eff)
            pcnt_d = (pcnt_q == P_LAST) ? '0 : pcnt_q + PW'(1);
         if (tick) begin
            if (!bus.dir) begin
               if (count_q == MAX_V) begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = count_q + DATA_WIDTH'(1);
               end
            end else begin
               if (count_q == '0) begin
                  count_d = MAX_V;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = count_q - DATA_WIDTH'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         pcnt_q  <= '0;
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   // A push into a full FIFO still lands when the head is popped in the same cycle.
   assign full     = (fill == DEPTH_V);
   assign empty    = (fill == '0);
   assign push_req = bus.lap && !bus.clear;
   assign pop_ok   = bus.lap_pop && !empty && !bus.clear;
   assign push_ok  = push_req && (!full || pop_ok);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         lap_ovf_q <= 1'b0;
      end else if (bus.clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         lap_ovf_q <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop_ok)
            fill <= fill + (AW+1)'(1);
         else if (pop_ok && !push_ok)
            fill <= fill - (AW+1)'(1);
         if (push_req && !push_ok)
            lap_ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && push_ok)
         mem[wr_ptr] <= count_q;
   end

   assign bus.count     = count_q;
   assign bus.running   = (state_q == RUN);
   assign bus.wrap      = wrap_q;
   assign bus.lap_data  = mem[rd_ptr];
   assign bus.lap_valid = !empty;
   assign bus.lap_full  = full;
   assign bus.lap_ovf   = lap_ovf_q;
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Self-checking bench for stopwatch_lap_timer: one instance with PRESCALE=1,
// one with PRESCALE=3, expected values queued at stimulus time.
module tb_stopwatch_lap_timer;
   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   stopwatch_lap_timer_if #(.DATA_WIDTH(16)) ifa ();
   stopwatch_lap_timer_if #(.DATA_WIDTH(16)) ifb ();

   stopwatch_lap_timer #(.DATA_WIDTH(16), .MAX(99), .PRESCALE(1), .LAP_DEPTH(4)) dut_a (
      .clk(clk), .resetn(resetn), .bus(ifa)
   );
   stopwatch_lap_timer #(.DATA_WIDTH(16), .MAX(99), .PRESCALE(3), .LAP_DEPTH(4)) dut_b (
      .clk(clk), .resetn(resetn), .bus(ifb)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int exp_q[$];
   int wrap_q[$];
   int lap_q[$];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int e;
      resetn = 1'b0;
      {ifa.start, ifa.stop, ifa.clear, ifa.dir, ifa.lap, ifa.lap_pop} = '0;
      {ifb.start, ifb.stop, ifb.clear, ifb.dir, ifb.lap, ifb.lap_pop} = '0;
      cyc();
      cyc();
      n_cmp++;
      if ({ifa.count, ifa.running, ifa.wrap, ifa.lap_valid, ifa.lap_full, ifa.lap_ovf} !== 21'd0) begin
         n_bad++;
         $display("FAIL reset_a: got count=%0d run=%b wrap=%b v=%b f=%b o=%b, want all 0",
                  ifa.count, ifa.running, ifa.wrap, ifa.lap_valid, ifa.lap_full, ifa.lap_ovf);
      end
      n_cmp++;
      if ({ifb.count, ifb.running, ifb.wrap, ifb.lap_valid} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_b: got count=%0d run=%b, want 0 0", ifb.count, ifb.running);
      end
      resetn = 1'b1;
      exp_q.push_back(0);
      cyc();
      e = exp_q.pop_front();
      n_cmp++;
      if (ifa.count !== 16'(e)) begin
         n_bad++;
         $display("FAIL idle_hold: got %0d want %0d", ifa.count, e);
      end
   endtask

   task automatic test_start_count();
      int e;
      ifa.start = 1'b1;
      exp_q.push_back(1);
      cyc();
      ifa.start = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (ifa.count !== 16'(e) || ifa.running !== 1'b1) begin
         n_bad++;
         $display("FAIL start_edge: got count=%0d run=%b want %0d 1", ifa.count, ifa.running, e);
      end
      exp_q.push_back(2);
      exp_q.push_back(3);
      for (int i = 0; i < 2; i++) begin
         cyc();
         e = exp_q.pop_front();
         n_cmp++;
         if (ifa.count !== 16'(e)) begin
            n_bad++;
            $display("FAIL count_up: got %0d want %0d", ifa.count, e);
         end
      end
   endtask

   task automatic test_wrap_up();
      int e, w;
      for (int i = 0; i < 95; i++) cyc();
      n_cmp++;
      if (ifa.count !== 16'd98) begin
         n_bad++;
         $display("FAIL reach_98: got %0d want 98", ifa.count);
      end
      exp_q.push_back(99); wrap_q.push_back(0);
      exp_q.push_back(0);  wrap_q.push_back(1);
      exp_q.push_back(1);  wrap_q.push_back(0);
      exp_q.push_back(2);  wrap_q.push_back(0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         e = exp_q.pop_front();
         w = wrap_q.pop_front();
         n_cmp++;
         if (ifa.count !== 16'(e) || ifa.wrap !== 1'(w)) begin
            n_bad++;
            $display("FAIL wrap_up: got count=%0d wrap=%b want %0d %0d", ifa.count, ifa.wrap, e, w);
         end
      end
   endtask

   task automatic test_down();
      int e, w;
      ifa.dir = 1'b1;
      exp_q.push_back(1);  wrap_q.push_back(0);
      exp_q.push_back(0);  wrap_q.push_back(0);
      exp_q.push_back(99); wrap_q.push_back(1);
      exp_q.push_back(98); wrap_q.push_back(0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         e = exp_q.pop_front();
         w = wrap_q.pop_front();
         n_cmp++;
         if (ifa.count !== 16'(e) || ifa.wrap !== 1'(w)) begin
            n_bad++;
            $display("FAIL wrap_down: got count=%0d wrap=%b want %0d %0d", ifa.count, ifa.wrap, e, w);
         end
      end
      ifa.dir = 1'b0;
   endtask

   task automatic test_start_stop();
      ifa.clear = 1'b1;
      cyc();
      ifa.clear = 1'b0;
      n_cmp++;
      if (ifa.count !== 16'd0 || ifa.running !== 1'b1) begin
         n_bad++;
         $display("FAIL clear_run: got count=%0d run=%b want 0 1", ifa.count, ifa.running);
      end
      for (int i = 0; i < 5; i++) cyc();
      ifa.start = 1'b1;
      ifa.stop  = 1'b1;
      cyc();
      ifa.start = 1'b0;
      ifa.stop  = 1'b0;
      n_cmp++;
      if (ifa.count !== 16'd5 || ifa.running !== 1'b0) begin
         n_bad++;
         $display("FAIL start_stop: got count=%0d run=%b want 5 0", ifa.count, ifa.running);
      end
      cyc();
      n_cmp++;
      if (ifa.count !== 16'd5) begin
         n_bad++;
         $display("FAIL stop_hold: got %0d want 5", ifa.count);
      end
      ifa.clear = 1'b1;
      ifa.start = 1'b1;
      cyc();
      ifa.clear = 1'b0;
      ifa.start = 1'b0;
      n_cmp++;
      if (ifa.count !== 16'd0 || ifa.running !== 1'b1) begin
         n_bad++;
         $display("FAIL clear_start: got count=%0d run=%b want 0 1", ifa.count, ifa.running);
      end
   endtask

   task automatic test_lap();
      int e;
      for (int i = 0; i < 3; i++) cyc();
      n_cmp++;
      if (ifa.count !== 16'd3) begin
         n_bad++;
         $display("FAIL lap_pre: got %0d want 3", ifa.count);
      end
      ifa.lap = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) lap_q.push_back(3 + i);
         cyc();
      end
      ifa.lap = 1'b0;
      n_cmp++;
      if ({ifa.lap_valid, ifa.lap_full, ifa.lap_ovf} !== 3'b111) begin
         n_bad++;
         $display("FAIL lap_full_ovf: got v/f/o=%b%b%b want 111", ifa.lap_valid, ifa.lap_full, ifa.lap_ovf);
      end
      ifa.stop = 1'b1;
      cyc();
      ifa.stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e = lap_q.pop_front();
         n_cmp++;
         if (ifa.lap_valid !== 1'b1 || ifa.lap_data !== 16'(e)) begin
            n_bad++;
            $display("FAIL lap_pop: got data=%0d v=%b want %0d 1", ifa.lap_data, ifa.lap_valid, e);
         end
         ifa.lap_pop = 1'b1;
         cyc();
         ifa.lap_pop = 1'b0;
      end
      n_cmp++;
      if ({ifa.lap_valid, ifa.lap_full, ifa.lap_ovf} !== 3'b001) begin
         n_bad++;
         $display("FAIL lap_drained: got v/f/o=%b%b%b want 001", ifa.lap_valid, ifa.lap_full, ifa.lap_ovf);
      end
      // count is frozen at 8 while stopped; push+pop on empty keeps the push
      ifa.lap     = 1'b1;
      ifa.lap_pop = 1'b1;
      lap_q.push_back(8);
      cyc();
      ifa.lap     = 1'b0;
      ifa.lap_pop = 1'b0;
      e = lap_q.pop_front();
      n_cmp++;
      if (ifa.lap_valid !== 1'b1 || ifa.lap_data !== 16'(e)) begin
         n_bad++;
         $display("FAIL push_pop_empty: got data=%0d v=%b want %0d 1", ifa.lap_data, ifa.lap_valid, e);
      end
      ifa.clear = 1'b1;
      ifa.lap   = 1'b1;
      cyc();
      ifa.clear = 1'b0;
      ifa.lap   = 1'b0;
      n_cmp++;
      if ({ifa.count, ifa.lap_valid, ifa.lap_ovf} !== 18'd0) begin
         n_bad++;
         $display("FAIL clear_flush: got count=%0d v=%b o=%b want 0 0 0", ifa.count, ifa.lap_valid, ifa.lap_ovf);
      end
   endtask

   task automatic test_prescale();
      int e;
      ifb.start = 1'b1;
      exp_q.push_back(0);
      cyc();
      ifb.start = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (ifb.count !== 16'(e) || ifb.running !== 1'b1) begin
         n_bad++;
         $display("FAIL ps_start: got count=%0d run=%b want %0d 1", ifb.count, ifb.running, e);
      end
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         e = exp_q.pop_front();
         n_cmp++;
         if (ifb.count !== 16'(e)) begin
            n_bad++;
            $display("FAIL ps_run: got %0d want %0d", ifb.count, e);
         end
      end
      ifb.stop = 1'b1;
      cyc();
      ifb.stop = 1'b0;
      cyc();
      cyc();
      n_cmp++;
      if (ifb.count !== 16'd1 || ifb.running !== 1'b0) begin
         n_bad++;
         $display("FAIL ps_stop: got count=%0d run=%b want 1 0", ifb.count, ifb.running);
      end
      ifb.start = 1'b1;
      exp_q.push_back(1);
      exp_q.push_back(2);
      for (int i = 0; i < 2; i++) begin
         cyc();
         ifb.start = 1'b0;
         e = exp_q.pop_front();
         n_cmp++;
         if (ifb.count !== 16'(e)) begin
            n_bad++;
            $display("FAIL ps_resume: got %0d want %0d", ifb.count, e);
         end
      end
      ifb.lap = 1'b1;
      cyc();
      ifb.lap = 1'b0;
      n_cmp++;
      if (ifb.lap_valid !== 1'b1 || ifb.lap_data !== 16'd2) begin
         n_bad++;
         $display("FAIL ps_lap: got data=%0d v=%b want 2 1", ifb.lap_data, ifb.lap_valid);
      end
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      n_cmp++;
      if ({ifb.count, ifb.running, ifb.wrap, ifb.lap_valid, ifb.lap_full, ifb.lap_ovf} !== 21'd0) begin
         n_bad++;
         $display("FAIL ps_reset: got count=%0d run=%b wrap=%b v=%b f=%b o=%b, want all 0",
                  ifb.count, ifb.running, ifb.wrap, ifb.lap_valid, ifb.lap_full, ifb.lap_ovf);
      end
      cyc();
      cyc();
      cyc();
      n_cmp++;
      if (ifb.count !== 16'd0 || ifb.running !== 1'b0) begin
         n_bad++;
         $display("FAIL ps_post_reset: got count=%0d run=%b want 0 0", ifb.count, ifb.running);
      end
   endtask

   initial begin
      test_reset();
      test_start_count();
      test_wrap_up();
      test_down();
      test_start_stop();
      test_lap();
      test_prescale();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
